// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Byte-wide RAM port controller shared by instruction fetch (IF)
//            and the MEM stage. Arbitrates the two requesters, sequences
//            1/2/4 single-byte RAM accesses and assembles little-endian words.
// Options  : MEM_CTRL_FAIR_EN - alternate grants when both sides request;
//            undefined gives fixed MEM-over-IF priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state, next_state;
  logic [RAM_AW-1:0] base;
  logic [2:0]        cnt;          // edges elapsed since the accept edge
  logic [1:0]        last_k;       // index of the final byte (N-1)
  logic              owner_mem;    // 1 = current transaction belongs to MEM
  logic [31:0]       wdata;
  logic [31:0]       acc;

  logic              grant_any;
  logic              grant_mem;
  logic [RAM_AW-1:0] sel_addr;
  logic [1:0]        sel_last_k;
  logic [2:0]        cnt_inc;
  logic [RAM_AW-1:0] next_addr;
  logic              rd_last;
  logic              wr_last;
  logic [31:0]       acc_ins;
  logic [7:0]        wr_byte;
  logic [1:0]        rd_idx;

  // Only the low RAM_AW address bits reach the RAM; the rest are dropped.
  generate
    if (ADDR_W > RAM_AW) begin : g_addr_upper
      logic unused_upper;
      assign unused_upper = ^{if_addr[ADDR_W-1:RAM_AW], mem_addr[ADDR_W-1:RAM_AW]};
    end else begin : g_addr_full
      logic unused_upper;
      assign unused_upper = 1'b0;
    end
  endgenerate

`ifdef MEM_CTRL_FAIR_EN
  logic last_grant_mem;  // 1 = MEM was granted most recently

  // Remember which side won the last arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant_mem <= 1'b0;
    else if (state == IDLE && grant_any)
      last_grant_mem <= grant_mem;
  end

  // MEM wins unless both request and MEM was served last.
  always_comb begin
    grant_mem = mem_req & (~if_req | ~last_grant_mem);
  end
`else
  // Fixed priority: MEM always beats IF.
  always_comb begin
    grant_mem = mem_req;
  end
`endif

  // Arbitration result and per-beat address / byte selection.
  always_comb begin
    grant_any  = if_req | mem_req;
    sel_addr   = grant_mem ? mem_addr[RAM_AW-1:0] : if_addr[RAM_AW-1:0];
    sel_last_k = 2'd3;
    if (grant_mem) begin
      case (mem_len)
        2'b00:   sel_last_k = 2'd0;
        2'b01:   sel_last_k = 2'd1;
        default: sel_last_k = 2'd3;
      endcase
    end
    cnt_inc   = cnt + 3'd1;
    next_addr = base + {{(RAM_AW-3){1'b0}}, cnt_inc};
    rd_last   = (cnt == ({1'b0, last_k} + 3'd1));
    wr_last   = (cnt == {1'b0, last_k});
    rd_idx    = cnt[1:0] - 2'd1;
    acc_ins   = acc;
    case (rd_idx)
      2'd0:    acc_ins[7:0]   = ram_din;
      2'd1:    acc_ins[15:8]  = ram_din;
      2'd2:    acc_ins[23:16] = ram_din;
      default: acc_ins[31:24] = ram_din;
    endcase
    case (cnt_inc[1:0])
      2'd0:    wr_byte = wdata[7:0];
      2'd1:    wr_byte = wdata[15:8];
      2'd2:    wr_byte = wdata[23:16];
      default: wr_byte = wdata[31:24];
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    if_done    = (state == DONE) && !owner_mem;
    mem_done   = (state == DONE) && owner_mem;
    case (state)
      IDLE: if (grant_any) next_state = (grant_mem && mem_we) ? WR : RD;
      RD:   if (rd_last)   next_state = DONE;
      WR:   if (wr_last)   next_state = DONE;
      default:             next_state = IDLE;
    endcase
  end

  // Transaction datapath: latch the winner, drive RAM beats, assemble reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      cnt       <= '0;
      last_k    <= '0;
      owner_mem <= 1'b0;
      wdata     <= '0;
      acc       <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_dout  <= '0;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            base      <= sel_addr;
            cnt       <= '0;
            last_k    <= sel_last_k;
            owner_mem <= grant_mem;
            wdata     <= mem_wdata;
            acc       <= '0;
            ram_addr  <= sel_addr;
            if (grant_mem && mem_we) begin
              ram_we   <= 1'b1;
              ram_dout <= mem_wdata[7:0];
            end
          end
        end
        RD: begin
          cnt <= cnt_inc;
          if (cnt < {1'b0, last_k})
            ram_addr <= next_addr;
          if (cnt != 3'd0)
            acc <= acc_ins;
          if (rd_last) begin
            if (owner_mem)
              mem_rdata <= acc_ins;
            else
              if_data <= acc_ins;
          end
        end
        WR: begin
          cnt <= cnt_inc;
          if (cnt < {1'b0, last_k}) begin
            ram_addr <= next_addr;
            ram_dout <= wr_byte;
          end else begin
            ram_we <= 1'b0;
          end
        end
        default: ram_we <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed self-checking bench for mem_ctrl with a byte RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        busy;

  logic [7:0]  ram [0:131071];
  logic [16:0] alog [0:3];
  logic        extra_done;
  int          total = 0;
  int          bad = 0;

  mem_ctrl #(.ADDR_W(32), .RAM_AW(17)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: registered read, write on strobe.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  // Drive one transaction from its accept edge to its done pulse.
  task automatic run_txn(input bit use_mem, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output bit saw_we);
    lat = -1; data = '0; saw_we = 1'b0;
    if (use_mem) begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    @(posedge clk); #1;
    alog[0] = ram_addr;
    saw_we = saw_we | ram_we;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k < 4) alog[k] = ram_addr;
      saw_we = saw_we | ram_we;
      if (use_mem ? mem_done : if_done) begin
        lat = k;
        data = use_mem ? mem_rdata : if_data;
        break;
      end
    end
    mem_req = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
    extra_done = use_mem ? mem_done : if_done;
  endtask

  task automatic test_reset;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if ({if_done, mem_done, ram_we} !== 3'b000) begin bad++; $display("FAIL reset_done_we got=%b exp=000", {if_done, mem_done, ram_we}); end
    total++; if (ram_addr !== 17'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
    total++; if ({if_data, mem_rdata} !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {if_data, mem_rdata}); end
  endtask

  task automatic test_if_read;
    int lat; logic [31:0] d; bit w;
    run_txn(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, lat, d, w);
    total++; if (lat !== 5) begin bad++; $display("FAIL if_read_latency got=%0d exp=5", lat); end
    total++; if (d !== 32'h44332211) begin bad++; $display("FAIL if_read_data got=%h exp=44332211", d); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (alog[k] !== 17'h100 + 17'(k)) begin bad++; $display("FAIL if_read_addr%0d got=%h exp=%h", k, alog[k], 17'h100 + 17'(k)); end
    end
    total++; if (w !== 1'b0) begin bad++; $display("FAIL if_read_we got=%0b exp=0", w); end
    total++; if (extra_done !== 1'b0) begin bad++; $display("FAIL if_read_pulse_width got=%0b exp=0", extra_done); end
  endtask

  task automatic test_store_half;
    int lat; logic [31:0] d; bit w;
    run_txn(1'b1, 1'b1, 2'b01, 32'h2, 32'hDEADBEEF, lat, d, w);
    total++; if (lat !== 2) begin bad++; $display("FAIL store_half_latency got=%0d exp=2", lat); end
    total++; if (ram[2] !== 8'hEF) begin bad++; $display("FAIL store_half_b0 got=%h exp=ef", ram[2]); end
    total++; if (ram[3] !== 8'hBE) begin bad++; $display("FAIL store_half_b1 got=%h exp=be", ram[3]); end
    total++; if (ram[4] !== 8'h5A) begin bad++; $display("FAIL store_half_b2_untouched got=%h exp=5a", ram[4]); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL store_half_we_idle got=%0b exp=0", ram_we); end
    total++; if (if_data !== 32'h44332211) begin bad++; $display("FAIL store_half_if_hold got=%h exp=44332211", if_data); end
  endtask

  task automatic test_byte_load;
    int lat; logic [31:0] d; bit w;
    run_txn(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, lat, d, w);
    total++; if (lat !== 2) begin bad++; $display("FAIL byte_load_latency got=%0d exp=2", lat); end
    total++; if (d !== 32'h00000080) begin bad++; $display("FAIL byte_load_data got=%h exp=00000080", d); end
    run_txn(1'b1, 1'b0, 2'b01, 32'h100, 32'h0, lat, d, w);
    total++; if (lat !== 3) begin bad++; $display("FAIL half_load_latency got=%0d exp=3", lat); end
    total++; if (d !== 32'h00002211) begin bad++; $display("FAIL half_load_data got=%h exp=00002211", d); end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] d; bit w;
    logic [16:0] exp_a [0:3];
    exp_a[0] = 17'h1FFFE; exp_a[1] = 17'h1FFFF; exp_a[2] = 17'h00000; exp_a[3] = 17'h00001;
    run_txn(1'b1, 1'b0, 2'b10, 32'hFFF1FFFE, 32'h0, lat, d, w);
    total++; if (lat !== 5) begin bad++; $display("FAIL wrap_latency got=%0d exp=5", lat); end
    total++; if (d !== 32'h0201B2A1) begin bad++; $display("FAIL wrap_data got=%h exp=0201b2a1", d); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (alog[k] !== exp_a[k]) begin bad++; $display("FAIL wrap_addr%0d got=%h exp=%h", k, alog[k], exp_a[k]); end
    end
  endtask

  task automatic test_conflict;
    int mem_at = -1; int if_at = -1;
    mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h10; if_addr = 32'h100;
    mem_req = 1'b1; if_req = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mem_done && mem_at < 0) begin mem_at = k; mem_req = 1'b0; end
      if (if_done && if_at < 0) begin if_at = k; if_req = 1'b0; end
    end
    mem_req = 1'b0; if_req = 1'b0;
    total++; if (mem_at !== 2) begin bad++; $display("FAIL conflict_mem_first got=%0d exp=2", mem_at); end
    total++; if (if_at !== 9) begin bad++; $display("FAIL conflict_if_after got=%0d exp=9", if_at); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n_mem = 0; int n_if = 0;
    mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h10; if_addr = 32'h100;
    mem_req = 1'b1; if_req = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (mem_done) n_mem++;
      if (if_done) n_if++;
    end
    mem_req = 1'b0; if_req = 1'b0;
`ifdef MEM_CTRL_FAIR_EN
    total++; if (n_mem !== 2) begin bad++; $display("FAIL fair_mem_grants got=%0d exp=2", n_mem); end
    total++; if (n_if !== 2) begin bad++; $display("FAIL fair_if_grants got=%0d exp=2", n_if); end
`else
    total++; if (n_mem !== 5) begin bad++; $display("FAIL starve_mem_grants got=%0d exp=5", n_mem); end
    total++; if (n_if !== 0) begin bad++; $display("FAIL starve_if_grants got=%0d exp=0", n_if); end
`endif
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_read;
    int lat; logic [31:0] d; bit w; bit saw = 1'b0;
    if_addr = 32'h100; if_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    total++; if ({if_data, ram_addr} !== 49'h0) begin bad++; $display("FAIL midrst_outputs got=%h exp=0", {if_data, ram_addr}); end
    if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      saw = saw | if_done | mem_done;
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%0b exp=0", saw); end
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 2'b11, 32'h100, 32'h0, lat, d, w);
    total++; if (lat !== 5) begin bad++; $display("FAIL midrst_reissue_latency got=%0d exp=5", lat); end
    total++; if (d !== 32'h44332211) begin bad++; $display("FAIL midrst_reissue_data got=%h exp=44332211", d); end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) ram[i] = 8'h00;
    ram[17'h100] = 8'h11; ram[17'h101] = 8'h22; ram[17'h102] = 8'h33; ram[17'h103] = 8'h44;
    ram[17'h4] = 8'h5A;
    ram[17'h10] = 8'h80; ram[17'h11] = 8'hFF;
    ram[17'h1FFFE] = 8'hA1; ram[17'h1FFFF] = 8'hB2; ram[17'h0] = 8'h01; ram[17'h1] = 8'h02;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_if_read;
    test_store_half;
    test_byte_load;
    test_wrap;
    test_conflict;
    test_back_to_back;
    test_reset_mid_read;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
